// File: rtl/pulse_pkg.sv
// Shared types and defaults for the pulse generator / measurement pair.
// PRI is encoded as (rise-to-rise period - 1) on both sides.
package pulse_pkg;

    localparam int PW_W_DEF  = 8;
    localparam int PRI_W_DEF = 16;

    // Reported PRI = measured period minus this offset.
    localparam int PRI_OFFSET = 1;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

endpackage

// File: rtl/pulse_edge_det.sv
// Input conditioning and edge detection for pulse_meas.
// PULSE_MEAS_SYNC_EN adds a 2-flop synchronizer in front of p_s.
module pulse_edge_det
    import pulse_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic p_s;
    logic p_d;

`ifdef PULSE_MEAS_SYNC_EN
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            p_s  <= 1'b0;
        end else begin
            meta <= pulse_in;
            p_s  <= meta;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) p_s <= 1'b0;
        else     p_s <= pulse_in;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) p_d <= 1'b0;
        else     p_d <= p_s;
    end

    assign level = p_s;
    assign rise  = p_s & ~p_d;
    assign fall  = ~p_s & p_d;

endmodule

// File: rtl/pulse_meas.sv
// Pulse-train receiver: measures pulse width and PRI in clk cycles.
// Define PULSE_MEAS_SYNC_EN for asynchronous pulse_in sources.
module pulse_meas
    import pulse_pkg::*;
#(
    parameter int PW_W  = PW_W_DEF,
    parameter int PRI_W = PRI_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pulse_in,
    output logic [PW_W-1:0]  pw_out,
    output logic [PRI_W-1:0] pri_out,
    output logic             meas_valid,
    output logic             pw_sat,
    output logic             timeout
);

    localparam logic [PW_W-1:0]  PW_MAX  = '1;
    localparam logic [PRI_W-1:0] PRI_MAX = '1;
    localparam logic [PW_W-1:0]  PW_ONE  = PW_W'(1);
    localparam logic [PRI_W-1:0] PRI_ONE = PRI_W'(1);
    localparam logic [PRI_W-1:0] PRI_OFS = PRI_W'(PRI_OFFSET);

    logic level;
    logic rise;
    logic fall;

    state_t           state;
    logic [PRI_W-1:0] period_cnt;
    logic [PW_W-1:0]  pw_cnt;
    logic [PW_W-1:0]  pw_hold;
    logic             sat;
    logic             sat_hold;

    pulse_edge_det u_edge (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .level    (level),
        .rise     (rise),
        .fall     (fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            period_cnt <= '0;
            pw_cnt     <= '0;
            pw_hold    <= '0;
            sat        <= 1'b0;
            sat_hold   <= 1'b0;
            pw_out     <= '0;
            pri_out    <= '0;
            meas_valid <= 1'b0;
            pw_sat     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!en) begin
                state      <= IDLE;
                period_cnt <= '0;
                pw_cnt     <= '0;
                sat        <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (rise) begin
                            period_cnt <= PRI_ONE;
                            pw_cnt     <= PW_ONE;
                            sat        <= 1'b0;
                            state      <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (period_cnt == PRI_MAX) begin
                            timeout    <= 1'b1;
                            period_cnt <= '0;
                            pw_cnt     <= '0;
                            state      <= IDLE;
                        end else begin
                            period_cnt <= period_cnt + PRI_ONE;
                            if (fall) begin
                                pw_hold  <= pw_cnt;
                                sat_hold <= sat;
                                state    <= LOW;
                            end else if (level) begin
                                if (pw_cnt == PW_MAX) sat <= 1'b1;
                                else pw_cnt <= pw_cnt + PW_ONE;
                            end
                        end
                    end
                    LOW: begin
                        // A rise on the final count still closes the period.
                        if (rise) begin
                            pw_out     <= pw_hold;
                            pri_out    <= period_cnt - PRI_OFS;
                            pw_sat     <= sat_hold;
                            meas_valid <= 1'b1;
                            timeout    <= 1'b0;
                            period_cnt <= PRI_ONE;
                            pw_cnt     <= PW_ONE;
                            sat        <= 1'b0;
                            state      <= HIGH;
                        end else if (period_cnt == PRI_MAX) begin
                            timeout    <= 1'b1;
                            period_cnt <= '0;
                            pw_cnt     <= '0;
                            state      <= IDLE;
                        end else begin
                            period_cnt <= period_cnt + PRI_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/pulse_meas.md
# pulse_meas

Pulse-train receiver for the radar waveform path: samples an incoming pulse stream and measures each pulse's high width and repetition interval in `clk` cycles. It is the receive-side counterpart of the pulse generator. It reports results in the same encoding the generator is programmed with, so a loopback produces the programmed PW and PRI values. It is used for self-test and for characterising external pulse sources.

## Interface
Parameters:
- `PW_W`, default 8: pulse-width measurement width.
- `PRI_W`, default 16: period counter and PRI measurement width.

Ports:
- `clk`, in, 1: 100 MHz system clock.
- `rst`, in, 1: reset. **Asynchronous, active-high.**
- `en`, in, 1: measurement enable. While low, the FSM is held in IDLE and the outputs hold their values.
- `pulse_in`, in, 1: pulse train; may be asynchronous when `PULSE_MEAS_SYNC_EN` is defined.
- `pw_out`, out, `PW_W`: high width of the last completed pulse, in cycles (saturating).
- `pri_out`, out, `PRI_W`: last rise-to-rise period in cycles minus 1 (generator PRI encoding).
- `meas_valid`, out, 1: one-cycle strobe; `pw_out`, `pri_out` and `pw_sat` are updated in the same cycle.
- `pw_sat`, out, 1: the pulse reported with the current `meas_valid` exceeded `2^PW_W-1` cycles.
- `timeout`, out, 1: sticky flag. Set when no complete period arrives within `2^PRI_W-1` cycles; cleared by the next `meas_valid` or by reset.

## Operation
- Front end:
  - `p_s` is the conditioned input; `p_d` is `p_s` delayed by one cycle.
  - rise = `p_s & ~p_d`; fall = `~p_s & p_d`.
- States: IDLE, HIGH, LOW.
- IDLE: on rise, set `period_cnt`=1 and `pw_cnt`=1, then go to HIGH. Before the first rise no measurement exists, so `meas_valid` is never asserted here.
- HIGH:
  - Every cycle `period_cnt`++.
  - When `p_s`=1, `pw_cnt`++ (saturating at `2^PW_W-1`; record a sat bit).
  - On fall: latch `pw_hold`=`pw_cnt` and `sat_hold`, then go to LOW.
- LOW:
  - Every cycle `period_cnt`++.
  - On rise: `pw_out`=`pw_hold`, `pri_out`=`period_cnt`-1, `pw_sat`=`sat_hold`, `meas_valid`=1, `timeout`=0.
  - Restart `period_cnt`=1 and `pw_cnt`=1, clear the sat bit, and go to HIGH.
- Timeout: if `period_cnt` reaches `2^PRI_W-1` in HIGH or LOW without a rise, set `timeout`=1 and go to IDLE. No `meas_valid` is issued.
- Priority: a rise in the same cycle as the saturation count wins. The measurement is reported with `pri_out`=`2^PRI_W-2` and no timeout.
- Constant-high input (generator PW > PRI) produces no fall, so it times out from HIGH. Constant-low input times out from LOW, or stays in IDLE.
- Minimum legal train: PW=1, period=2. This reports `pw_out`=1, `pri_out`=1 every 2 cycles.
- `en` deasserted: next cycle the FSM goes to IDLE and the counters clear. The outputs and `timeout` hold. After re-enable, the first `meas_valid` requires two rises.
- All outputs are registered.

## Timing
- Reset values: `pw_out`=0, `pri_out`=0, `meas_valid`=0, `pw_sat`=0, `timeout`=0. The state is IDLE and all sync/edge/counter registers are 0.
- Reset asserted mid-operation clears everything immediately. The first rise after reset only arms the FSM.
- Latency, with the sync compiled in: `meas_valid` rises on the 3rd `clk` edge, counting the edge that first samples `pulse_in` high at the start of the closing pulse.
- Latency, with the sync compiled out: `meas_valid` rises on the 2nd such edge.
- Throughput: one measurement per input period; back-to-back strobes are possible every 2 cycles.

## Configuration
- `PULSE_MEAS_SYNC_EN` defined: `pulse_in` passes through a 2-flop synchronizer before `p_s`. This adds one cycle of latency and is safe for asynchronous sources.
- Not defined: `p_s` is a single register sampling `pulse_in`, which must be synchronous to `clk`. Measured values are identical in both builds; only latency differs.

## Structure
- Package `pulse_pkg` holds:
  - the state enum (IDLE/HIGH/LOW);
  - default `PW_W`/`PRI_W` constants, shared with the generator;
  - the PRI encoding note (period-1).
- Sub-module `pulse_edge_det`: the optional synchronizer, `p_d` register, and `rise`/`fall` outputs.
- The FSM, counters and output registers live in `pulse_meas`.

## Test plan
1. Train PW=3, period 10, `en`=1 -> from the second rise onward, `meas_valid` every 10 cycles with `pw_out`=3, `pri_out`=9, `pw_sat`=0.
2. Train PW=1, period 2 -> `meas_valid` every 2 cycles, `pw_out`=1, `pri_out`=1.
3. `PRI_W`=8, one rise then constant high -> `timeout`=1 at 255 cycles after the rise, no `meas_valid`. A following normal train clears `timeout` on its first `meas_valid`.
4. `PW_W`=8, pulse high 300 cycles, period 400 -> `pw_out`=255, `pw_sat`=1, `pri_out`=399.
5. `rst` pulsed mid-pulse in HIGH -> all outputs 0 in the same cycle. The next rise gives no strobe; the rise after gives a correct measurement.
6. `en` dropped for 20 cycles mid-train (PW=3, period 10) -> no strobes while low. After re-enable, the first strobe comes on the second rise with `pw_out`=3, `pri_out`=9.
